elelock_ctrl: RTL and testbench
===============================

// Module: elelock_ctrl
// PURPOSE
//   Session controller for the electronic-lock datapath (keypad shift register, debouncer, lock flop).
//   Counts entered digits, times out stale entries and checks the lock result after a full code.
//   Limits failed attempts with a lockout period, auto-relocks after opening, and flags tamper.
//   Drives the datapath's close input and gates its keypad.
// PARAMETERS
//   CODE_LEN    4     digits per code attempt (>=1)
//   MAX_FAIL    3     consecutive failed attempts that trigger LOCKOUT (1..2**FAIL_W-1)
//   FAIL_W      2     width of fail_cnt
//   ENTRY_TMO   1000  idle cycles allowed between digits before the entry is abandoned
//   RELOCK_CYC  2000  cycles with door shut in OPEN before auto-relock
//   LOCKOUT_CYC 5000  cycles the keypad stays blocked after MAX_FAIL failures
//   TMR_W       16    timer width (must hold max of the three cycle counts)
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   key_press  in   1       1-cycle pulse per debounced digit; same edge as the datapath key shift
//   unlocked   in   1       inverse of the datapath lock output (1 = open)
//   door_open  in   1       door sensor, 1 = open; synchronous to clk
//   close      out  1       registered 1-cycle pulse: relock and clear datapath key registers
//   kp_block   out  1       1 = keypad gated; datapath must ignore digits
//   alarm      out  1       1 while in LOCKOUT
//   tamper     out  1       sticky: door opened while locked; cleared only by reset
//   fail_cnt   out  FAIL_W  consecutive failed attempts
//   state      out  3       IDLE=0 ENTRY=1 CHECK=2 OPEN=3 LOCKOUT=4
// BEHAVIOUR
//   Reset (sync, priority over all): state=IDLE, close=0, kp_block=0, alarm=0, tamper=0,
//     fail_cnt=0, digit count=0, timer=0.
//   All outputs are registered. close defaults to 0 each cycle and is never high 2 cycles running.
//   IDLE
//     key_press -> ENTRY, digits=1, timer=0.
//     If CODE_LEN==1, key_press goes directly to CHECK.
//   ENTRY
//     key_press: digits+1 and timer=0. If digits+1==CODE_LEN -> CHECK, timer=0.
//     No press with timer==ENTRY_TMO-1 -> close=1, digits=0, go to IDLE. fail_cnt is unchanged.
//   CHECK
//     key_press is ignored; digits are not counted.
//     unlocked==1 in any CHECK cycle -> OPEN, fail_cnt=0, timer=0.
//     Otherwise, after 2 CHECK cycles (lock flop lags the key shift by 1 edge) the attempt fails:
//       close=1, digits=0.
//       If fail_cnt+1==MAX_FAIL -> LOCKOUT, timer=0, fail_cnt=MAX_FAIL.
//       Else fail_cnt+1 -> IDLE.
//   OPEN
//     door_open=1 holds timer at 0.
//     Door shut: timer counts. At timer==RELOCK_CYC-1 -> close=1, go to IDLE.
//     unlocked falls while in OPEN -> IDLE with no close pulse.
//     key_press in OPEN is ignored.
//   LOCKOUT
//     kp_block=1 and alarm=1 are set on entry and held for the whole state.
//     key_press is ignored.
//     At timer==LOCKOUT_CYC-1 -> close=1, fail_cnt=0, kp_block=0, alarm=0, go to IDLE.
//   Tamper: door_open=1 while unlocked=0 in any state other than OPEN -> tamper=1 next edge.
//   Timers are not free-running: they reset to 0 on every state change and never wrap.
//   Simultaneous events:
//     key_press on the ENTRY timeout cycle counts as a press; no timeout.
//     unlocked on the 2nd CHECK cycle counts as success.
//   Reset asserted mid-state returns to IDLE on the next edge; no close pulse is emitted.
// TESTING (bench params: CODE_LEN=4 MAX_FAIL=3 ENTRY_TMO=8 RELOCK_CYC=6 LOCKOUT_CYC=10)
//   Correct code: 4 key_press pulses, model unlocked=1 one edge after the 4th -> state=OPEN;
//     door stays shut -> close pulses exactly 6 cycles after OPEN entry; state=IDLE.
//   Wrong code 3x: each attempt -> close pulse 2 cycles into CHECK, fail_cnt=1,2.
//     3rd attempt -> LOCKOUT, alarm=1, kp_block=1.
//     After 10 cycles -> close pulse, fail_cnt=0, alarm=0, state=IDLE.
//   Entry timeout: 2 presses then 8 idle cycles -> close pulse, state=IDLE, fail_cnt unchanged.
//     A press on the 8th cycle instead keeps ENTRY with digits=3.
//   Door held: in OPEN, door_open=1 for 20 cycles -> no close.
//     Release -> close 6 cycles later.
//   Tamper and presses while blocked:
//     door_open=1 in IDLE -> tamper=1, stays 1 until reset.
//     key_press during LOCKOUT or CHECK -> no state or count change.
//   Reset mid-ENTRY and mid-LOCKOUT -> next edge: IDLE, all outputs at reset values, close=0.

Source files
------------

// File: rtl/elelock_if.sv
// Signal bundle between the lock datapath (master) and its session controller (slave).
// key_press is a single-cycle strobe with no ready: the controller consumes every pulse it sees; kp_block tells the datapath to drop digits.
interface elelock_if #(
  parameter int FAIL_W = 2
);
  logic              key_press;
  logic              unlocked;
  logic              door_open;
  logic              close;
  logic              kp_block;
  logic              alarm;
  logic              tamper;
  logic [FAIL_W-1:0] fail_cnt;
  logic [2:0]        state;

  modport master (
    output key_press, unlocked, door_open,
    input  close, kp_block, alarm, tamper, fail_cnt, state
  );

  modport slave (
    input  key_press, unlocked, door_open,
    output close, kp_block, alarm, tamper, fail_cnt, state
  );
endinterface

// File: rtl/elelock_ctrl.sv
// Electronic-lock session controller: digit counting, entry timeout, result check,
// failed-attempt lockout, auto-relock and tamper flag. All outputs are registered.
module elelock_ctrl #(
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int FAIL_W      = 2,
  parameter int ENTRY_TMO   = 1000,
  parameter int RELOCK_CYC  = 2000,
  parameter int LOCKOUT_CYC = 5000,
  parameter int TMR_W       = 16
) (
  input  logic      clk,
  input  logic      reset,
  elelock_if.slave  bus
);

  localparam int DIG_W = $clog2(CODE_LEN + 1);

  localparam logic [TMR_W-1:0]  ENTRY_LAST   = TMR_W'(ENTRY_TMO - 1);
  localparam logic [TMR_W-1:0]  RELOCK_LAST  = TMR_W'(RELOCK_CYC - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);
  // The lock flop lags the key shift by one edge, so the result is final on the 2nd CHECK cycle.
  localparam logic [TMR_W-1:0]  CHECK_LAST   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);
  localparam logic [DIG_W:0]    CODE_LEN_X   = (DIG_W + 1)'(CODE_LEN);
  localparam logic [DIG_W-1:0]  DIG_ONE      = DIG_W'(1);
  localparam logic [DIG_W:0]    DIG_INC_ONE  = (DIG_W + 1)'(1);
  localparam logic [FAIL_W:0]   MAX_FAIL_X   = (FAIL_W + 1)'(MAX_FAIL);
  localparam logic [FAIL_W:0]   FAIL_INC_ONE = (FAIL_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               close_q, close_d;
  logic               tamper_q, tamper_d;
  logic               kp_block_q, alarm_q;
  logic [DIG_W:0]     digits_inc;
  logic [FAIL_W:0]    fail_inc;

  assign digits_inc = {1'b0, digits_q} + DIG_INC_ONE;
  assign fail_inc   = {1'b0, fail_q} + FAIL_INC_ONE;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    digits_d = digits_q;
    fail_d   = fail_q;
    close_d  = 1'b0;
    tamper_d = tamper_q | (bus.door_open & ~bus.unlocked & (state_q != S_OPEN));

    unique case (state_q)
      S_IDLE: begin
        if (bus.key_press) begin
          digits_d = DIG_ONE;
          state_d  = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
        // A press on the timeout cycle wins over the timeout.
        if (bus.key_press) begin
          digits_d = digits_inc[DIG_W-1:0];
          timer_d  = '0;
          if (digits_inc == CODE_LEN_X) state_d = S_CHECK;
        end else if (timer_q == ENTRY_LAST) begin
          close_d  = 1'b1;
          digits_d = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      S_CHECK: begin
        if (bus.unlocked) begin
          fail_d   = '0;
          digits_d = '0;
          state_d  = S_OPEN;
        end else if (timer_q == CHECK_LAST) begin
          close_d  = 1'b1;
          digits_d = '0;
          if (fail_inc == MAX_FAIL_X) begin
            fail_d  = MAX_FAIL_X[FAIL_W-1:0];
            state_d = S_LOCKOUT;
          end else begin
            fail_d  = fail_inc[FAIL_W-1:0];
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      S_OPEN: begin
        // Someone relocked by hand: no close pulse needed.
        if (!bus.unlocked) begin
          state_d = S_IDLE;
        end else if (bus.door_open) begin
          timer_d = '0;
        end else if (timer_q == RELOCK_LAST) begin
          close_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == LOCKOUT_LAST) begin
          close_d = 1'b1;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      digits_q   <= '0;
      fail_q     <= '0;
      close_q    <= 1'b0;
      tamper_q   <= 1'b0;
      kp_block_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      digits_q   <= digits_d;
      fail_q     <= fail_d;
      close_q    <= close_d;
      tamper_q   <= tamper_d;
      kp_block_q <= (state_d == S_LOCKOUT);
      alarm_q    <= (state_d == S_LOCKOUT);
    end
  end

  assign bus.close    = close_q;
  assign bus.kp_block = kp_block_q;
  assign bus.alarm    = alarm_q;
  assign bus.tamper   = tamper_q;
  assign bus.fail_cnt = fail_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Bench for elelock_ctrl: scenario tasks with inline checks plus a close-pulse scoreboard
// holding the cycle at which each close pulse is due.
module tb_elelock_ctrl;

  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int FAIL_W      = 2;
  localparam int ENTRY_TMO   = 8;
  localparam int RELOCK_CYC  = 6;
  localparam int LOCKOUT_CYC = 10;
  localparam int TMR_W       = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elelock_if #(.FAIL_W(FAIL_W)) bus();

  elelock_ctrl #(
    .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL), .FAIL_W(FAIL_W), .ENTRY_TMO(ENTRY_TMO),
    .RELOCK_CYC(RELOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .TMR_W(TMR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Close-pulse scoreboard: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus.close === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL close_unexpected got close=1 at cycle %0d expected none", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (cyc !== exp_cyc) begin
          bad++;
          $display("FAIL close_timing got cycle %0d expected %0d", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press();
    bus.key_press = 1'b1;
    step(1);
    bus.key_press = 1'b0;
  endtask

  task automatic enter_code();
    repeat (CODE_LEN) press();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.key_press = 1'b0;
    bus.unlocked = 1'b0;
    bus.door_open = 1'b0;
    step(3);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got %0d want 0", bus.state); end
    total++; if (bus.close !== 1'b0) begin bad++; $display("FAIL rst_close got %b want 0", bus.close); end
    total++; if (bus.kp_block !== 1'b0) begin bad++; $display("FAIL rst_kp_block got %b want 0", bus.kp_block); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL rst_alarm got %b want 0", bus.alarm); end
    total++; if (bus.tamper !== 1'b0) begin bad++; $display("FAIL rst_tamper got %b want 0", bus.tamper); end
    total++; if (bus.fail_cnt !== 2'd0) begin bad++; $display("FAIL rst_fail_cnt got %0d want 0", bus.fail_cnt); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_open_relock();
    enter_code();
    total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL open_check1 got %0d want 2", bus.state); end
    step(1);
    total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL open_check2 got %0d want 2", bus.state); end
    bus.unlocked = 1'b1;
    step(1);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL open_enter got %0d want 3", bus.state); end
    exp_q.push_back(cyc + RELOCK_CYC);
    for (int i = 0; i < RELOCK_CYC - 1; i++) begin
      step(1);
      total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL open_hold got %0d want 3", bus.state); end
    end
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL open_relock got %0d want 0", bus.state); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL open_close_missing got %0d pending want 0", exp_q.size()); end
    bus.unlocked = 1'b0;
    step(1);
  endtask

  task automatic test_wrong_lockout();
    for (int a = 1; a < MAX_FAIL; a++) begin
      enter_code();
      exp_q.push_back(cyc + 2);
      press();
      total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL wrong_press_in_check got %0d want 2", bus.state); end
      step(1);
      total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL wrong_idle got %0d want 0", bus.state); end
      total++; if (bus.fail_cnt !== FAIL_W'(a)) begin bad++; $display("FAIL wrong_fail_cnt got %0d want %0d", bus.fail_cnt, a); end
    end
    enter_code();
    exp_q.push_back(cyc + 2);
    step(2);
    total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL lock_state got %0d want 4", bus.state); end
    total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL lock_alarm got %b want 1", bus.alarm); end
    total++; if (bus.kp_block !== 1'b1) begin bad++; $display("FAIL lock_kp_block got %b want 1", bus.kp_block); end
    total++; if (bus.fail_cnt !== 2'd3) begin bad++; $display("FAIL lock_fail_cnt got %0d want 3", bus.fail_cnt); end
    exp_q.push_back(cyc + LOCKOUT_CYC);
    press();
    total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL lock_press got %0d want 4", bus.state); end
    step(LOCKOUT_CYC - 2);
    total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL lock_alarm_hold got %b want 1", bus.alarm); end
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL lock_exit got %0d want 0", bus.state); end
    total++; if (bus.fail_cnt !== 2'd0) begin bad++; $display("FAIL lock_exit_fail_cnt got %0d want 0", bus.fail_cnt); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL lock_exit_alarm got %b want 0", bus.alarm); end
    total++; if (bus.kp_block !== 1'b0) begin bad++; $display("FAIL lock_exit_kp_block got %b want 0", bus.kp_block); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL lock_close_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_entry_timeout();
    enter_code();
    exp_q.push_back(cyc + 2);
    step(2);
    total++; if (bus.fail_cnt !== 2'd1) begin bad++; $display("FAIL tmo_setup_fail got %0d want 1", bus.fail_cnt); end
    press();
    press();
    exp_q.push_back(cyc + ENTRY_TMO);
    step(ENTRY_TMO - 1);
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL tmo_wait got %0d want 1", bus.state); end
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL tmo_idle got %0d want 0", bus.state); end
    total++; if (bus.fail_cnt !== 2'd1) begin bad++; $display("FAIL tmo_fail_cnt got %0d want 1", bus.fail_cnt); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL tmo_close_missing got %0d pending want 0", exp_q.size()); end
    press();
    press();
    step(ENTRY_TMO - 1);
    press();
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL tmo_late_press got %0d want 1", bus.state); end
    press();
    total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL tmo_fourth_digit got %0d want 2", bus.state); end
    exp_q.push_back(cyc + 2);
    step(2);
    total++; if (bus.fail_cnt !== 2'd2) begin bad++; $display("FAIL tmo_after_fail got %0d want 2", bus.fail_cnt); end
  endtask

  task automatic test_door_held();
    enter_code();
    step(1);
    bus.unlocked = 1'b1;
    step(1);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL door_open_state got %0d want 3", bus.state); end
    total++; if (bus.fail_cnt !== 2'd0) begin bad++; $display("FAIL door_fail_clear got %0d want 0", bus.fail_cnt); end
    bus.door_open = 1'b1;
    step(20);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL door_held got %0d want 3", bus.state); end
    total++; if (bus.tamper !== 1'b0) begin bad++; $display("FAIL door_no_tamper got %b want 0", bus.tamper); end
    bus.door_open = 1'b0;
    exp_q.push_back(cyc + RELOCK_CYC);
    step(RELOCK_CYC - 1);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL door_release_hold got %0d want 3", bus.state); end
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL door_relock got %0d want 0", bus.state); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL door_close_missing got %0d pending want 0", exp_q.size()); end
    bus.unlocked = 1'b0;
    step(1);
    enter_code();
    step(1);
    bus.unlocked = 1'b1;
    step(2);
    bus.unlocked = 1'b0;
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL manual_relock got %0d want 0", bus.state); end
    step(2);
  endtask

  task automatic test_tamper();
    total++; if (bus.tamper !== 1'b0) begin bad++; $display("FAIL tamper_pre got %b want 0", bus.tamper); end
    bus.door_open = 1'b1;
    step(1);
    total++; if (bus.tamper !== 1'b1) begin bad++; $display("FAIL tamper_set got %b want 1", bus.tamper); end
    bus.door_open = 1'b0;
    step(3);
    total++; if (bus.tamper !== 1'b1) begin bad++; $display("FAIL tamper_sticky got %b want 1", bus.tamper); end
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL tamper_state got %0d want 0", bus.state); end
  endtask

  task automatic test_reset_mid();
    press();
    press();
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL midrst_entry got %0d want 1", bus.state); end
    reset = 1'b1;
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL midrst_e_state got %0d want 0", bus.state); end
    total++; if (bus.close !== 1'b0) begin bad++; $display("FAIL midrst_e_close got %b want 0", bus.close); end
    total++; if (bus.tamper !== 1'b0) begin bad++; $display("FAIL midrst_e_tamper got %b want 0", bus.tamper); end
    reset = 1'b0;
    step(1);
    for (int a = 0; a < MAX_FAIL; a++) begin
      enter_code();
      exp_q.push_back(cyc + 2);
      step(2);
    end
    total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL midrst_lockout got %0d want 4", bus.state); end
    step($urandom_range(1, LOCKOUT_CYC - 3));
    reset = 1'b1;
    step(1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL midrst_l_state got %0d want 0", bus.state); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL midrst_l_alarm got %b want 0", bus.alarm); end
    total++; if (bus.kp_block !== 1'b0) begin bad++; $display("FAIL midrst_l_kp_block got %b want 0", bus.kp_block); end
    total++; if (bus.fail_cnt !== 2'd0) begin bad++; $display("FAIL midrst_l_fail_cnt got %0d want 0", bus.fail_cnt); end
    total++; if (bus.close !== 1'b0) begin bad++; $display("FAIL midrst_l_close got %b want 0", bus.close); end
    reset = 1'b0;
    step(LOCKOUT_CYC + 2);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL midrst_after got %0d want 0", bus.state); end
  endtask

  initial begin
    test_reset();
    test_open_relock();
    test_wrong_lockout();
    test_entry_timeout();
    test_door_held();
    test_tamper();
    test_reset_mid();
    step(2);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL final_pending got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
